// File: rtl/foc_sched_pkg.sv
// Shared definitions for the FOC torque scheduler.
//   sched_state_t : state encoding, also exported on the debug/UART state port
//   SETPOINT_W    : width of the iq/id setpoints and measured currents
//   CNT_W         : width of the dwell timer
package foc_sched_pkg;

    localparam int SETPOINT_W = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP_POS = 3'd1,
        ST_HOLD_POS = 3'd2,
        ST_RAMP_NEG = 3'd3,
        ST_HOLD_NEG = 3'd4,
        ST_STOP     = 3'd5,
        ST_FAULT    = 3'd6
    } sched_state_t;

endpackage

// File: rtl/foc_torque_scheduler_if.sv
// Connection between the FOC core/control side and the torque scheduler.
//   master : FOC core side; drives init_done, en_idq, iq, enable, clr_fault
//            and consumes the setpoints and status.
//   slave  : the scheduler; consumes the inputs above and drives
//            id_aim, iq_aim, run, fault, state.
interface foc_torque_scheduler_if;
    import foc_sched_pkg::*;

    logic                         init_done;
    logic                         en_idq;
    logic signed [SETPOINT_W-1:0] iq;
    logic                         enable;
    logic                         clr_fault;
    logic signed [SETPOINT_W-1:0] id_aim;
    logic signed [SETPOINT_W-1:0] iq_aim;
    logic                         run;
    logic                         fault;
    logic [2:0]                   state;

    modport master (
        output init_done, en_idq, iq, enable, clr_fault,
        input  id_aim, iq_aim, run, fault, state
    );

    modport slave (
        input  init_done, en_idq, iq, enable, clr_fault,
        output id_aim, iq_aim, run, fault, state
    );

endinterface

// File: rtl/foc_slew_step.sv
// Combinational slew limiter: moves cur toward target by at most step and
// lands exactly on target when it is within reach, so it never overshoots.
//   cur    : current setpoint (signed)
//   target : setpoint being approached (signed)
//   step   : maximum change per call (unsigned)
//   nxt    : next setpoint (signed)
module foc_slew_step
    import foc_sched_pkg::*;
(
    input  logic signed [SETPOINT_W-1:0] cur,
    input  logic signed [SETPOINT_W-1:0] target,
    input  logic        [SETPOINT_W-1:0] step,
    output logic signed [SETPOINT_W-1:0] nxt
);

    // One extra bit so target-cur and cur+/-step cannot wrap.
    logic signed [SETPOINT_W:0] diff;
    logic signed [SETPOINT_W:0] step_s;
    logic signed [SETPOINT_W:0] up;
    logic signed [SETPOINT_W:0] dn;

    always_comb begin
        diff   = {target[SETPOINT_W-1], target} - {cur[SETPOINT_W-1], cur};
        step_s = {1'b0, step};
        up     = {cur[SETPOINT_W-1], cur} + step_s;
        dn     = {cur[SETPOINT_W-1], cur} - step_s;
        if (diff > step_s) begin
            nxt = up[SETPOINT_W-1:0];
        end else if (diff < -step_s) begin
            nxt = dn[SETPOINT_W-1:0];
        end else begin
            nxt = target;
        end
    end

endmodule

// File: rtl/foc_torque_scheduler.sv
// FOC torque-profile scheduler: slews iq_aim to +AMP, dwells, slews to -AMP,
// dwells, repeats. Advances only on en_idq control-cycle pulses.
// Optional over-current trip compiled in with `define FOC_SCHED_TRIP_EN.
//
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : foc_torque_scheduler_if.slave
//               in : init_done, en_idq, iq, enable, clr_fault
//               out: id_aim (always 0), iq_aim, run, fault, state
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE     0  | iq_aim=0, waiting for init_done && enable
// RAMP_POS 1  | slewing toward +AMP
// HOLD_POS 2  | dwelling at +AMP for DWELL control cycles
// RAMP_NEG 3  | slewing toward -AMP
// HOLD_NEG 4  | dwelling at -AMP for DWELL control cycles
// STOP     5  | enable dropped; slewing back to 0
// FAULT    6  | over-current trip; iq_aim=0 until cleared
module foc_torque_scheduler
    import foc_sched_pkg::*;
#(
    parameter logic [15:0] AMP        = 16'd200,
    parameter logic [15:0] SLEW       = 16'd4,
    parameter logic [15:0] DWELL      = 16'd4096,
    parameter logic [15:0] TRIP_LIMIT = 16'd1000,
    parameter logic [7:0]  TRIP_COUNT = 8'd16
) (
    input  logic                   clk,
    input  logic                   rstn,
    foc_torque_scheduler_if.slave  bus
);

    localparam logic signed [SETPOINT_W-1:0] AMP_POS   = $signed(AMP);
    localparam logic signed [SETPOINT_W-1:0] AMP_NEG   = -$signed(AMP);
    localparam logic        [CNT_W-1:0]      DWELL_EFF = (DWELL == 16'd0) ? 16'd1 : DWELL;

    sched_state_t                 state_q, state_d;
    logic signed [SETPOINT_W-1:0] iq_aim_q, iq_aim_d;
    logic        [CNT_W-1:0]      dwell_q, dwell_d;
    logic                         run_q, run_d;
    logic                         fault_q, fault_d;
    logic signed [SETPOINT_W-1:0] target;
    logic signed [SETPOINT_W-1:0] step_nxt;
    logic                         active;
    logic                         trip_hit;

    assign active = (state_q == ST_RAMP_POS) || (state_q == ST_HOLD_POS) ||
                    (state_q == ST_RAMP_NEG) || (state_q == ST_HOLD_NEG);

    always_comb begin
        case (state_q)
            ST_RAMP_POS: target = AMP_POS;
            ST_RAMP_NEG: target = AMP_NEG;
            default:     target = '0;
        endcase
    end

    foc_slew_step u_step (
        .cur    (iq_aim_q),
        .target (target),
        .step   (SLEW),
        .nxt    (step_nxt)
    );

`ifdef FOC_SCHED_TRIP_EN
    localparam logic [7:0] TRIP_EFF = (TRIP_COUNT == 8'd0) ? 8'd1 : TRIP_COUNT;

    logic        [7:0]            trip_q, trip_d, trip_inc;
    logic signed [SETPOINT_W-1:0] iq_neg;
    logic        [SETPOINT_W-1:0] iq_mag;
    logic                         over_limit;
    logic                         counting;

    // Trip counting only while the profile drives current (run states).
    always_comb begin
        iq_neg = -bus.iq;
        if (bus.iq == 16'sh8000) begin
            iq_mag = 16'h7FFF;
        end else if (bus.iq[SETPOINT_W-1]) begin
            iq_mag = $unsigned(iq_neg);
        end else begin
            iq_mag = $unsigned(bus.iq);
        end
        over_limit = iq_mag > TRIP_LIMIT;
        counting   = bus.init_done && (active || (state_q == ST_STOP));
        trip_inc   = trip_q + 8'd1;
        trip_hit   = counting && bus.en_idq && over_limit && (trip_inc >= TRIP_EFF);
        trip_d     = trip_q;
        if (!counting || trip_hit) begin
            trip_d = '0;
        end else if (bus.en_idq) begin
            trip_d = over_limit ? trip_inc : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trip_q <= '0;
        end else begin
            trip_q <= trip_d;
        end
    end
`else
    logic unused_trip;
    assign unused_trip = ^{bus.iq, TRIP_LIMIT, TRIP_COUNT};
    assign trip_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            iq_aim_q <= '0;
            dwell_q  <= '0;
            run_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            iq_aim_q <= iq_aim_d;
            dwell_q  <= dwell_d;
            run_q    <= run_d;
            fault_q  <= fault_d;
        end
    end

    // FAULT ignores init_done and en_idq; init_done loss overrides everything else.
    always_comb begin
        state_d  = state_q;
        iq_aim_d = iq_aim_q;
        dwell_d  = dwell_q;
        if (state_q == ST_FAULT) begin
            iq_aim_d = '0;
            if (bus.clr_fault && !bus.enable) begin
                state_d = ST_IDLE;
            end
        end else if (!bus.init_done) begin
            state_d  = ST_IDLE;
            iq_aim_d = '0;
            dwell_d  = '0;
        end else if (bus.en_idq) begin
            if (trip_hit) begin
                state_d  = ST_FAULT;
                iq_aim_d = '0;
                dwell_d  = '0;
            end else if (!bus.enable && active) begin
                state_d = ST_STOP;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        iq_aim_d = '0;
                        if (bus.enable) begin
                            state_d = ST_RAMP_POS;
                        end
                    end
                    ST_RAMP_POS: begin
                        iq_aim_d = step_nxt;
                        if (step_nxt == AMP_POS) begin
                            state_d = ST_HOLD_POS;
                            dwell_d = DWELL_EFF;
                        end
                    end
                    ST_HOLD_POS: begin
                        if (dwell_q <= 16'd1) begin
                            state_d = ST_RAMP_NEG;
                        end else begin
                            dwell_d = dwell_q - 16'd1;
                        end
                    end
                    ST_RAMP_NEG: begin
                        iq_aim_d = step_nxt;
                        if (step_nxt == AMP_NEG) begin
                            state_d = ST_HOLD_NEG;
                            dwell_d = DWELL_EFF;
                        end
                    end
                    ST_HOLD_NEG: begin
                        if (dwell_q <= 16'd1) begin
                            state_d = ST_RAMP_POS;
                        end else begin
                            dwell_d = dwell_q - 16'd1;
                        end
                    end
                    ST_STOP: begin
                        iq_aim_d = step_nxt;
                        if (step_nxt == 16'sd0) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        iq_aim_d = '0;
                    end
                endcase
            end
        end
    end

    // Status decoded from the next state and registered with it, so run/fault
    // change on the same edge as state.
    always_comb begin
        run_d = (state_d != ST_IDLE) && (state_d != ST_FAULT);
`ifdef FOC_SCHED_TRIP_EN
        fault_d = (state_d == ST_FAULT);
`else
        fault_d = 1'b0;
`endif
    end

    assign bus.id_aim = '0;
    assign bus.iq_aim = iq_aim_q;
    assign bus.run    = run_q;
    assign bus.fault  = fault_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_foc_torque_scheduler.sv
// Directed bench for foc_torque_scheduler. Two instances share all inputs:
// u_dut (AMP=200, SLEW=50, DWELL=3) and u_dut2 (AMP=200, SLEW=60, DWELL=3),
// both with TRIP_LIMIT=1000, TRIP_COUNT=4.
module tb_foc_torque_scheduler;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               init_done = 1'b0;
    logic               en_idq = 1'b0;
    logic signed [15:0] iq = '0;
    logic               enable = 1'b0;
    logic               clr_fault = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    foc_torque_scheduler_if bus1 ();
    foc_torque_scheduler_if bus2 ();

    assign bus1.init_done = init_done;
    assign bus1.en_idq    = en_idq;
    assign bus1.iq        = iq;
    assign bus1.enable    = enable;
    assign bus1.clr_fault = clr_fault;
    assign bus2.init_done = init_done;
    assign bus2.en_idq    = en_idq;
    assign bus2.iq        = iq;
    assign bus2.enable    = enable;
    assign bus2.clr_fault = clr_fault;

    foc_torque_scheduler #(
        .AMP(16'd200), .SLEW(16'd50), .DWELL(16'd3),
        .TRIP_LIMIT(16'd1000), .TRIP_COUNT(8'd4)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );

    foc_torque_scheduler #(
        .AMP(16'd200), .SLEW(16'd60), .DWELL(16'd3),
        .TRIP_LIMIT(16'd1000), .TRIP_COUNT(8'd4)
    ) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2.slave)
    );

    task automatic pulse();
        @(negedge clk) en_idq = 1'b1;
        @(negedge clk) en_idq = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        en_idq = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        init_done = 1'b1;
        enable    = 1'b1;
        rstn      = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus1.iq_aim !== 16'sd0) begin errors++; $display("FAIL reset iq_aim: got %0d want 0", bus1.iq_aim); end
        checks++; if (bus1.id_aim !== 16'sd0) begin errors++; $display("FAIL reset id_aim: got %0d want 0", bus1.id_aim); end
        checks++; if (bus1.state !== 3'd0) begin errors++; $display("FAIL reset state: got %0d want 0", bus1.state); end
        checks++; if (bus1.run !== 1'b0) begin errors++; $display("FAIL reset run: got %0b want 0", bus1.run); end
        checks++; if (bus1.fault !== 1'b0) begin errors++; $display("FAIL reset fault: got %0b want 0", bus1.fault); end
        rstn = 1'b1;
        @(negedge clk);
        // Mid-profile asynchronous reset: run 3 pulses (iq_aim=100) then
        // assert rstn away from any clock edge.
        pulses(3);
        checks++; if (bus1.iq_aim !== 16'sd100) begin errors++; $display("FAIL pre-reset iq_aim: got %0d want 100", bus1.iq_aim); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (bus1.iq_aim !== 16'sd0 || bus1.state !== 3'd0 || bus1.run !== 1'b0) begin
            errors++; $display("FAIL async reset: got iq_aim=%0d state=%0d run=%0b want 0/0/0", bus1.iq_aim, bus1.state, bus1.run);
        end
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_startup();
        int exp_iq [19] = '{50, 100, 150, 200, 200, 200, 200, 150, 100, 50, 0,
                            -50, -100, -150, -200, -200, -200, -200, -150};
        int exp_st [19] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 4, 4, 4, 1, 1};
        logic signed [15:0] e_iq;
        logic [2:0]         e_st;
        do_reset();
        iq = '0;
        init_done = 1'b1;
        enable = 1'b1;
        pulse();
        checks++; if (bus1.state !== 3'd1 || bus1.iq_aim !== 16'sd0 || bus1.run !== 1'b1) begin
            errors++; $display("FAIL startup enter: got state=%0d iq_aim=%0d run=%0b want 1/0/1", bus1.state, bus1.iq_aim, bus1.run);
        end
        for (int i = 0; i < 19; i++) begin
            pulse();
            e_iq = 16'(exp_iq[i]);
            e_st = 3'(exp_st[i]);
            checks++; if (bus1.iq_aim !== e_iq || bus1.state !== e_st) begin
                errors++; $display("FAIL startup step %0d: got iq_aim=%0d state=%0d want %0d/%0d", i, bus1.iq_aim, bus1.state, e_iq, e_st);
            end
        end
        checks++; if (bus1.id_aim !== 16'sd0) begin errors++; $display("FAIL startup id_aim: got %0d want 0", bus1.id_aim); end
    endtask

    task automatic test_non_multiple();
        int exp_iq [6] = '{0, 60, 120, 180, 200, 200};
        int exp_st [6] = '{1, 1, 1, 1, 2, 2};
        logic signed [15:0] e_iq;
        logic [2:0]         e_st;
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse();
            e_iq = 16'(exp_iq[i]);
            e_st = 3'(exp_st[i]);
            checks++; if (bus2.iq_aim !== e_iq || bus2.state !== e_st) begin
                errors++; $display("FAIL nonmult step %0d: got iq_aim=%0d state=%0d want %0d/%0d", i, bus2.iq_aim, bus2.state, e_iq, e_st);
            end
        end
    endtask

    task automatic test_stop_neg();
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        pulses(14);
        checks++; if (bus1.iq_aim !== -16'sd100 || bus1.state !== 3'd3) begin
            errors++; $display("FAIL stop setup: got iq_aim=%0d state=%0d want -100/3", bus1.iq_aim, bus1.state);
        end
        enable = 1'b0;
        pulse();
        checks++; if (bus1.iq_aim !== -16'sd100 || bus1.state !== 3'd5 || bus1.run !== 1'b1) begin
            errors++; $display("FAIL stop enter: got iq_aim=%0d state=%0d run=%0b want -100/5/1", bus1.iq_aim, bus1.state, bus1.run);
        end
        pulse();
        checks++; if (bus1.iq_aim !== -16'sd50 || bus1.state !== 3'd5) begin
            errors++; $display("FAIL stop step1: got iq_aim=%0d state=%0d want -50/5", bus1.iq_aim, bus1.state);
        end
        pulse();
        checks++; if (bus1.iq_aim !== 16'sd0 || bus1.state !== 3'd0 || bus1.run !== 1'b0) begin
            errors++; $display("FAIL stop end: got iq_aim=%0d state=%0d run=%0b want 0/0/0", bus1.iq_aim, bus1.state, bus1.run);
        end
    endtask

    task automatic test_init_loss();
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        pulses(10);
        checks++; if (bus1.iq_aim !== 16'sd100 || bus1.state !== 3'd3) begin
            errors++; $display("FAIL initloss setup: got iq_aim=%0d state=%0d want 100/3", bus1.iq_aim, bus1.state);
        end
        @(negedge clk) init_done = 1'b0;
        @(posedge clk) #1;
        checks++; if (bus1.iq_aim !== 16'sd0 || bus1.state !== 3'd0 || bus1.run !== 1'b0) begin
            errors++; $display("FAIL initloss: got iq_aim=%0d state=%0d run=%0b want 0/0/0", bus1.iq_aim, bus1.state, bus1.run);
        end
        @(negedge clk) init_done = 1'b1;
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1;
        @(negedge clk) en_idq = 1'b1;
        @(negedge clk);
        checks++; if (bus1.state !== 3'd1 || bus1.iq_aim !== 16'sd0) begin
            errors++; $display("FAIL b2b 1: got state=%0d iq_aim=%0d want 1/0", bus1.state, bus1.iq_aim);
        end
        @(negedge clk);
        checks++; if (bus1.iq_aim !== 16'sd50) begin errors++; $display("FAIL b2b 2: got iq_aim=%0d want 50", bus1.iq_aim); end
        @(negedge clk);
        checks++; if (bus1.iq_aim !== 16'sd100) begin errors++; $display("FAIL b2b 3: got iq_aim=%0d want 100", bus1.iq_aim); end
        en_idq = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus1.iq_aim !== 16'sd100) begin errors++; $display("FAIL b2b hold: got iq_aim=%0d want 100", bus1.iq_aim); end
    endtask

`ifdef FOC_SCHED_TRIP_EN
    task automatic test_trip();
        enable = 1'b0;
        do_reset();
        iq = '0;
        enable = 1'b1;
        pulses(2);
        iq = 16'sd1000;
        pulses(5);
        checks++; if (bus1.fault !== 1'b0) begin errors++; $display("FAIL trip at-limit: got fault=%0b want 0", bus1.fault); end
        iq = 16'sd1001;
        pulses(3);
        checks++; if (bus1.fault !== 1'b0) begin errors++; $display("FAIL trip 3 over: got fault=%0b want 0", bus1.fault); end
        iq = 16'sd0;
        pulse();
        iq = 16'sd1001;
        pulses(3);
        checks++; if (bus1.fault !== 1'b0 || bus1.state === 3'd6) begin
            errors++; $display("FAIL trip after clear: got fault=%0b state=%0d want 0/not 6", bus1.fault, bus1.state);
        end
        pulse();
        checks++; if (bus1.fault !== 1'b1 || bus1.state !== 3'd6 || bus1.iq_aim !== 16'sd0 || bus1.run !== 1'b0) begin
            errors++; $display("FAIL trip 4th: got fault=%0b state=%0d iq_aim=%0d run=%0b want 1/6/0/0", bus1.fault, bus1.state, bus1.iq_aim, bus1.run);
        end
        iq = 16'sd0;
        @(negedge clk) clr_fault = 1'b1;
        repeat (3) @(negedge clk);
        pulse();
        checks++; if (bus1.state !== 3'd6) begin errors++; $display("FAIL clr with enable: got state=%0d want 6", bus1.state); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (bus1.state !== 3'd0 || bus1.fault !== 1'b0) begin
            errors++; $display("FAIL clr fault: got state=%0d fault=%0b want 0/0", bus1.state, bus1.fault);
        end
        clr_fault = 1'b0;
        enable = 1'b1;
        pulse();
        iq = -16'sd32768;
        pulses(3);
        checks++; if (bus1.fault !== 1'b0) begin errors++; $display("FAIL sat 3: got fault=%0b want 0", bus1.fault); end
        pulse();
        checks++; if (bus1.fault !== 1'b1 || bus1.state !== 3'd6) begin
            errors++; $display("FAIL sat trip: got fault=%0b state=%0d want 1/6", bus1.fault, bus1.state);
        end
        iq = '0;
        enable = 1'b0;
        clr_fault = 1'b1;
        @(negedge clk) clr_fault = 1'b0;
    endtask
`else
    task automatic test_trip();
        enable = 1'b0;
        do_reset();
        iq = '0;
        enable = 1'b1;
        pulses(2);
        iq = -16'sd32768;
        pulses(3);
        iq = 16'sd1001;
        pulses(5);
        checks++; if (bus1.fault !== 1'b0 || bus1.run !== 1'b1) begin
            errors++; $display("FAIL no-trip build: got fault=%0b run=%0b want 0/1", bus1.fault, bus1.run);
        end
        iq = '0;
        enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_startup();
        test_non_multiple();
        test_stop_neg();
        test_init_loss();
        test_back_to_back();
        test_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
